// File: rtl/el2_dccm_bank_sram_if.sv
// el2_dccm_bank_sram_if: DCCM bank SRAM export bus between core (master) and bank array (slave)
// Ports carried:
//   dccm_clken/wren_bank/addr_bank/wr_data_bank/wr_ecc_bank : per-bank access from the core
//   dccm_bank_dout/dccm_bank_ecc                            : per-bank read word back to the core
//   inj_arm/bank/row/bit/double                             : one-shot read error injection control
//   inj_pending/init_done                                   : injection armed, zero-fill complete
interface el2_dccm_bank_sram_if #(
    parameter int NUM_BANKS = 4,
    parameter int ROW_BITS  = 8,
    parameter int DATA_W    = 32,
    parameter int ECC_W     = 7
);
    logic [NUM_BANKS-1:0]          dccm_clken;
    logic [NUM_BANKS-1:0]          dccm_wren_bank;
    logic [NUM_BANKS*ROW_BITS-1:0] dccm_addr_bank;
    logic [NUM_BANKS*DATA_W-1:0]   dccm_wr_data_bank;
    logic [NUM_BANKS*ECC_W-1:0]    dccm_wr_ecc_bank;
    logic [NUM_BANKS*DATA_W-1:0]   dccm_bank_dout;
    logic [NUM_BANKS*ECC_W-1:0]    dccm_bank_ecc;
    logic                          inj_arm;
    logic [$clog2(NUM_BANKS)-1:0]  inj_bank;
    logic [ROW_BITS-1:0]           inj_row;
    logic [5:0]                    inj_bit;
    logic                          inj_double;
    logic                          inj_pending;
    logic                          init_done;
    modport master (
        output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
               inj_arm, inj_bank, inj_row, inj_bit, inj_double,
        input  dccm_bank_dout, dccm_bank_ecc, inj_pending, init_done
    );
    modport slave (
        input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
               inj_arm, inj_bank, inj_row, inj_bit, inj_double,
        output dccm_bank_dout, dccm_bank_ecc, inj_pending, init_done
    );
endinterface

// File: rtl/el2_dccm_bank_sram.sv
// el2_dccm_bank_sram: banked DCCM SRAM model with post-reset zero-fill, read pipeline and ECC error injection
// Ports:
//   clk   : core clock
//   rst_l : asynchronous active-low reset
//   bus   : el2_dccm_bank_sram_if slave (bank accesses in, read words out, injection control/status)
module el2_dccm_bank_sram #(
    parameter int             NUM_BANKS = 4,
    parameter int             ROW_BITS  = 8,
    parameter int             DATA_W    = 32,
    parameter int             ECC_W     = 7,
    parameter int             RD_LAT    = 1,
    parameter logic [ECC_W-1:0] INIT_ECC = '0
) (
    input logic                 clk,
    input logic                 rst_l,
    el2_dccm_bank_sram_if.slave bus
);
    localparam int CW = DATA_W + ECC_W;
    localparam int BW = $clog2(NUM_BANKS);
    typedef enum logic {FILL, RUN} state_t;
    state_t              r_state, w_state_nx;
    logic [ROW_BITS-1:0] r_cnt;
    logic                r_pend, r_dbl;
    logic [BW-1:0]       r_bank;
    logic [ROW_BITS-1:0] r_row;
    logic [5:0]          r_bit;
    logic                w_fill, w_pend, w_dbl;
    logic [BW-1:0]       w_bank;
    logic [ROW_BITS-1:0] w_row;
    logic [5:0]          w_bit, w_bit_nx;
    logic [CW-1:0]       w_mask;
    logic [NUM_BANKS-1:0] w_hit;
    // An arm pulse takes effect in its own cycle, so a same-cycle matching read is injected.
    always_comb begin
        w_fill     = r_state == FILL;
        w_state_nx = (w_fill && r_cnt == '1) ? RUN : r_state;
        w_pend     = bus.inj_arm | r_pend;
        w_bank     = bus.inj_arm ? bus.inj_bank : r_bank;
        w_row      = bus.inj_arm ? bus.inj_row : r_row;
        w_bit      = bus.inj_arm ? bus.inj_bit : r_bit;
        w_dbl      = bus.inj_arm ? bus.inj_double : r_dbl;
        w_bit_nx   = (w_bit == 6'(CW - 1)) ? 6'd0 : w_bit + 6'd1;
        w_mask     = (CW'(1) << w_bit) | (w_dbl ? (CW'(1) << w_bit_nx) : '0);
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_bank  <= '0;
            r_row   <= '0;
            r_bit   <= '0;
            r_dbl   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_fill ? r_cnt + 1'b1 : r_cnt;
            r_pend  <= w_pend & ~|w_hit;
            r_bank  <= w_bank;
            r_row   <= w_row;
            r_bit   <= w_bit;
            r_dbl   <= w_dbl;
        end
    end
    assign bus.inj_pending = r_pend;
    assign bus.init_done   = r_state == RUN;
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [CW-1:0]       r_mem [2**ROW_BITS];
        logic [CW-1:0]       r_rd1, r_rd2, w_out, w_wdata;
        logic [ROW_BITS-1:0] w_addr, w_waddr;
        logic                w_we, w_rd;
        // Fill owns every bank; interface traffic is ignored until RUN.
        assign w_addr   = bus.dccm_addr_bank[b*ROW_BITS +: ROW_BITS];
        assign w_we     = w_fill | (bus.dccm_clken[b] & bus.dccm_wren_bank[b]);
        assign w_rd     = ~w_fill & bus.dccm_clken[b] & ~bus.dccm_wren_bank[b];
        assign w_waddr  = w_fill ? r_cnt : w_addr;
        assign w_wdata  = w_fill ? {INIT_ECC, {DATA_W{1'b0}}}
                                 : {bus.dccm_wr_ecc_bank[b*ECC_W +: ECC_W], bus.dccm_wr_data_bank[b*DATA_W +: DATA_W]};
        assign w_hit[b] = w_pend & w_rd & (w_bank == BW'(b)) & (w_addr == w_row);
        always_ff @(posedge clk) begin
            if (w_we) r_mem[w_waddr] <= w_wdata;
        end
        // Stage 1 holds the last read word while the bank is idle; stage 2 simply trails it.
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                r_rd1 <= '0;
                r_rd2 <= '0;
            end else begin
                r_rd1 <= w_rd ? r_mem[w_addr] ^ (w_hit[b] ? w_mask : '0) : r_rd1;
                r_rd2 <= r_rd1;
            end
        end
        assign w_out = (RD_LAT == 2) ? r_rd2 : r_rd1;
        assign bus.dccm_bank_dout[b*DATA_W +: DATA_W] = w_out[DATA_W-1:0];
        assign bus.dccm_bank_ecc[b*ECC_W +: ECC_W]    = w_out[CW-1:DATA_W];
    end
    a_inj_bit: assert property (@(posedge clk) disable iff (!rst_l) bus.inj_arm |-> int'(bus.inj_bit) < CW);
endmodule
